// File: rtl/sprite_attr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : sprite_attr_fetch
// Purpose  : Read-side master that walks a fixed table of multi-byte entries in
//            a one-cycle-latency block RAM and presents each packed entry on a
//            valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_attr_fetch #(
  parameter int addr_width_g      = 11,
  parameter int data_width_g      = 8,
  parameter int base_addr_g       = 0,
  parameter int entries_g         = 24,
  parameter int bytes_per_entry_g = 4
) (
  input  logic                                      clock,
  input  logic                                      reset_n,
  input  logic                                      start,
  input  logic                                      abort,
  output logic                                      busy,
  output logic                                      done,
  output logic [addr_width_g-1:0]                   ram_address,
  output logic                                      ram_clken,
  output logic                                      ram_wren,
  input  logic [data_width_g-1:0]                   ram_q,
  output logic                                      ent_valid,
  input  logic                                      ent_ready,
  output logic [$clog2(entries_g+1)-1:0]            ent_index,
  output logic [bytes_per_entry_g*data_width_g-1:0] ent_data
);

  localparam int c_iw = $clog2(entries_g + 1);
  localparam int c_bw = $clog2(bytes_per_entry_g + 1);
  localparam int c_ew = bytes_per_entry_g * data_width_g;

  localparam logic [addr_width_g-1:0] c_base      = addr_width_g'(base_addr_g);
  localparam logic [c_iw-1:0]         c_last_idx  = c_iw'(entries_g - 1);
  localparam logic [c_bw-1:0]         c_last_byte = c_bw'(bytes_per_entry_g - 1);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_issue   = 2'd1;
  localparam logic [1:0] c_st_last    = 2'd2;
  localparam logic [1:0] c_st_present = 2'd3;

  logic [1:0]              r_state;
  logic [c_iw-1:0]         r_index;
  logic [c_bw-1:0]         r_byte;
  logic [c_bw-1:0]         r_cap_slot;
  logic                    r_cap_en;
  logic                    r_done;
  logic [addr_width_g-1:0] r_addr;
  logic [c_ew-1:0]         r_data;

  // Entries are contiguous, so a running address that wraps at the RAM size
  // equals base + index*B + byte truncated to the address width.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= c_st_idle;
      r_index    <= '0;
      r_byte     <= '0;
      r_cap_slot <= '0;
      r_cap_en   <= 1'b0;
      r_done     <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_done   <= 1'b0;
      r_cap_en <= 1'b0;
      // Read data lands one cycle after its issue, overlapping the next issue.
      if (r_cap_en) begin
        r_data[r_cap_slot*data_width_g +: data_width_g] <= ram_q;
      end
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_state <= c_st_issue;
            r_index <= '0;
            r_byte  <= '0;
            r_addr  <= c_base;
          end
        end
        c_st_issue: begin
          if (abort) begin
            r_state <= c_st_idle;
          end else begin
            r_cap_en   <= 1'b1;
            r_cap_slot <= r_byte;
            if (r_byte == c_last_byte) begin
              r_state <= c_st_last;
            end else begin
              r_byte <= r_byte + 1'b1;
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        c_st_last: begin
          r_state <= abort ? c_st_idle : c_st_present;
        end
        c_st_present: begin
          if (abort) begin
            r_state <= c_st_idle;
          end else if (ent_ready) begin
            if (r_index == c_last_idx) begin
              r_state <= c_st_idle;
              r_done  <= 1'b1;
            end else begin
              r_state <= c_st_issue;
              r_index <= r_index + 1'b1;
              r_byte  <= '0;
              r_addr  <= r_addr + 1'b1;
            end
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign busy        = (r_state != c_st_idle);
  assign done        = r_done;
  assign ram_clken   = (r_state == c_st_issue);
  assign ram_wren    = 1'b0;
  assign ram_address = r_addr;
  assign ent_valid   = (r_state == c_st_present);
  assign ent_index   = r_index;
  assign ent_data    = r_data;

endmodule
`default_nettype wire

// File: tb/tb_sprite_attr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_attr_fetch
// Purpose  : Scoreboard bench for sprite_attr_fetch with default and wrapping
//            address configurations; RAM model returns RAM[a] = a[7:0].
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_attr_fetch;

  logic        clock;
  logic        reset_n;
  logic        start, abort, ent_ready;
  logic        busy, done, ram_clken, ram_wren, ent_valid;
  logic [10:0] ram_address;
  logic [7:0]  ram_q;
  logic [4:0]  ent_index;
  logic [31:0] ent_data;

  logic        start_w, abort_w, ent_ready_w;
  logic        busy_w, done_w, ram_clken_w, ram_wren_w, ent_valid_w;
  logic [10:0] ram_address_w;
  logic [7:0]  ram_q_w;
  logic [1:0]  ent_index_w;
  logic [31:0] ent_data_w;

  int checks = 0;
  int errors = 0;

  logic [36:0] sb_q[$];
  logic [33:0] sbw_q[$];

  sprite_attr_fetch dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .ram_address(ram_address), .ram_clken(ram_clken),
    .ram_wren(ram_wren), .ram_q(ram_q), .ent_valid(ent_valid),
    .ent_ready(ent_ready), .ent_index(ent_index), .ent_data(ent_data)
  );

  sprite_attr_fetch #(.base_addr_g(2040), .entries_g(3)) dut_w (
    .clock(clock), .reset_n(reset_n), .start(start_w), .abort(abort_w),
    .busy(busy_w), .done(done_w), .ram_address(ram_address_w),
    .ram_clken(ram_clken_w), .ram_wren(ram_wren_w), .ram_q(ram_q_w),
    .ent_valid(ent_valid_w), .ent_ready(ent_ready_w),
    .ent_index(ent_index_w), .ent_data(ent_data_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_clken)   ram_q   <= ram_address[7:0];
    if (ram_clken_w) ram_q_w <= ram_address_w[7:0];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ent_word(input int first);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(((first + k) % 2048) & 255);
    return w;
  endfunction

  task automatic push_main(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) sb_q.push_back({5'(i), ent_word(4 * i)});
  endtask

  // Monitors: pop the oldest expected entry at every handshake.
  always @(negedge clock) begin : mon_main
    logic [36:0] e;
    if (reset_n && ent_valid && ent_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra actual=%0h required=none", {ent_index, ent_data});
      end else begin
        e = sb_q.pop_front();
        chk("sb_entry", {ent_index, ent_data}, e);
      end
    end
  end

  always @(negedge clock) begin : mon_wrap
    logic [33:0] e;
    if (reset_n && ent_valid_w && ent_ready_w) begin
      if (sbw_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sbw_extra actual=%0h required=none", {ent_index_w, ent_data_w});
      end else begin
        e = sbw_q.pop_front();
        chk("sbw_entry", {ent_index_w, ent_data_w}, e);
      end
    end
  end

  task automatic start_pulse();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clock); #1;
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk(nm, 64'(seen), 64'd1);
  endtask

  initial begin : stim
    int first_v, last_v, done_c, done_n, en_n, xfer_n, hold, bad, rel, n, dn, got;
    logic [10:0] addrs[12];

    start = 0; abort = 0; ent_ready = 1;
    start_w = 0; abort_w = 0; ent_ready_w = 1;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;

    // Reset with random inputs
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      start = 1'($urandom); abort = 1'($urandom); ent_ready = 1'($urandom);
      #2;
      chk("rst_ctrl", {busy, done, ent_valid, ram_clken, ram_wren}, 0);
      chk("rst_vals", {ram_address, ent_index, ent_data}, 0);
    end
    @(posedge clock); #1 reset_n = 1'b1; start = 0; abort = 0; ent_ready = 1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      if (ram_clken || busy || ent_valid || done) bad++;
    end
    chk("idle_after_release", 64'(bad), 0);

    // Full scan with a stray start pulse mid-scan
    push_main(0, 23);
    first_v = -1; last_v = -1; done_c = -1; done_n = 0; en_n = 0; xfer_n = 0;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      if (k <= 4) begin
        chk("issue_clken", 64'(ram_clken), 1);
        chk("issue_addr", 64'(ram_address), 64'(k - 1));
      end
      if (ram_clken) en_n++;
      if (ent_valid && first_v < 0) first_v = k;
      if (ent_valid && ent_index == 5'd23 && last_v < 0) last_v = k;
      if (ent_valid && ent_ready) xfer_n++;
      if (done) begin
        done_n++;
        done_c = k;
        chk("busy_at_done", 64'(busy), 0);
      end
      if (k == 20) start = 1'b1;
      if (k == 21) start = 1'b0;
      @(posedge clock); #1;
    end
    chk("first_valid_cycle", 64'(first_v), 6);
    chk("last_valid_cycle", 64'(last_v), 144);
    chk("done_cycle", 64'(done_c), 145);
    chk("done_count", 64'(done_n), 1);
    chk("ram_enables", 64'(en_n), 96);
    chk("transfers", 64'(xfer_n), 24);

    // Backpressure on entry 2
    push_main(0, 23);
    start_pulse();
    hold = 0; bad = 0; rel = 0; got = 0;
    for (int k = 0; k < 400; k++) begin
      if (rel == 1) begin
        chk("bp_next_clken", 64'(ram_clken), 1);
        chk("bp_next_addr", 64'(ram_address), 12);
        rel = 2;
      end
      if (ent_valid && ent_index == 5'd2 && hold < 10) begin
        ent_ready = 1'b0;
        if (ent_data != 32'h0B0A0908 || ram_clken) bad++;
        hold++;
      end else if (ent_valid && ent_index == 5'd2 && hold == 10) begin
        ent_ready = 1'b1;
        hold = 11;
        rel = 1;
      end
      if (done) begin
        got = 1;
        break;
      end
      @(posedge clock); #1;
    end
    chk("bp_stable", 64'(bad), 0);
    chk("bp_hold_len", 64'(hold), 11);
    chk("bp_done", 64'(got), 1);

    // Abort during entry 5 issue
    push_main(0, 4);
    start_pulse();
    got = 0;
    for (int k = 0; k < 200; k++) begin
      if (ram_clken && ent_index == 5'd5) begin
        abort = 1'b1;
        got = 1;
        break;
      end
      @(posedge clock); #1;
    end
    chk("abort_reached", 64'(got), 1);
    @(posedge clock); #1 abort = 1'b0;
    chk("abort_outs", {busy, ent_valid, ram_clken}, 0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      if (done || ram_clken) bad++;
    end
    chk("abort_quiet", 64'(bad), 0);
    push_main(0, 23);
    start_pulse();
    chk("restart_clken", 64'(ram_clken), 1);
    chk("restart_addr_idx", {ram_address, ent_index}, 0);
    wait_done(200, "restart_done");

    // Async reset while entry 7 is held
    push_main(0, 6);
    start_pulse();
    got = 0;
    for (int k = 0; k < 200; k++) begin
      if (ent_valid && ent_index == 5'd7) begin
        ent_ready = 1'b0;
        got = 1;
        break;
      end
      @(posedge clock); #1;
    end
    chk("entry7_reached", 64'(got), 1);
    repeat (2) @(posedge clock);
    @(negedge clock); #2 reset_n = 1'b0;
    #1;
    chk("async_rst_outs", {busy, ent_valid, ram_clken, done}, 0);
    ent_ready = 1'b1;
    bad = 0;
    @(posedge clock); #1 reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      if (done || busy) bad++;
    end
    chk("post_rst_quiet", 64'(bad), 0);
    push_main(0, 23);
    start_pulse();
    wait_done(200, "post_rst_done");

    // Address wrap-around configuration
    for (int i = 0; i < 3; i++) sbw_q.push_back({2'(i), ent_word(2040 + 4 * i)});
    @(posedge clock); #1 start_w = 1'b1;
    @(posedge clock); #1 start_w = 1'b0;
    n = 0; dn = 0;
    for (int k = 0; k < 40; k++) begin
      if (ram_clken_w) begin
        if (n < 12) addrs[n] = ram_address_w;
        n++;
      end
      if (done_w) dn++;
      @(posedge clock); #1;
    end
    chk("wrap_enables", 64'(n), 12);
    chk("wrap_done", 64'(dn), 1);
    for (int i = 0; i < 12; i++) chk("wrap_addr", 64'(addrs[i]), 64'((2040 + i) % 2048));

    chk("sb_drain", 64'(sb_q.size()), 0);
    chk("sbw_drain", 64'(sbw_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
